tick_scheduler: RTL and testbench
=================================

Name: tick_scheduler

Overview:
Shared timebase controller. One free-running prescaler produces a 1-cycle `tick` every TICK_DIV clocks. NCH requesters time-share it through round-robin load arbitration. Each granted channel counts down a programmed number of ticks and pulses `done`. It replaces per-consumer clock dividers in the display, debounce and blink logic.

Parameters:
TICK_DIV, 50_000_000, clock cycles per tick (>=1; 1 means tick every enabled cycle)
NCH, 4, number of requester channels
CNT_W, 8, width of per-channel tick count

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
en  in  1  prescaler enable; low freezes prescaler and all countdowns
req  in  NCH  per-channel load request (level)
ticks  in  NCH*CNT_W  per-channel tick count; slice i = bits [i*CNT_W +: CNT_W]
cancel  in  NCH  per-channel abort (1-cycle pulse)
ack  out  NCH  load accepted (1-cycle pulse)
busy  out  NCH  channel counting
done  out  NCH  countdown complete (1-cycle pulse)
tick  out  1  shared tick pulse

Behaviour:
- Reset (async, rst=1): prescaler=0, rr pointer=0, all counters=0; ack, busy, done, tick = 0 immediately. Reset mid-run discards all pending work; no done is produced.
- Prescaler:
  - counts 0..TICK_DIV-1 while en=1 and wraps to 0.
  - tick is registered: high for one cycle when the counter wraps.
  - en=0: counter holds and tick=0.
  - Cycle 0 is the first cycle after rst falls. With en=1, tick is high in cycles TICK_DIV-1, 2*TICK_DIV-1, ...
- Arbitration:
  - eligible(i) = req[i] & ~busy[i] & ~ack[i] & ~cancel[i].
  - At most one grant per cycle, round-robin starting at the pointer; the pointer moves to granted+1 mod NCH.
  - Grant decided in cycle k; at edge k+1: ack[i]=1 for one cycle, counter[i] loaded from the ticks slice, busy[i]=1.
  - Requester holds req and ticks stable until ack. A req still high after done is re-granted.
- Zero count: a grant with ticks=0 asserts ack[i] and done[i] in the same cycle; busy[i] stays 0.
- Countdown:
  - Channel state per channel: IDLE/RUN, with RUN equal to busy.
  - On each tick, every RUN channel decrements.
  - Tick in a cycle where counter[i]==1: next edge sets done[i]=1 for one cycle and busy[i]=0.
  - A tick coincident with the load edge does not decrement; counting starts at the next tick.
  - Latency from ack to done is between (ticks-1)*TICK_DIV+1 and ticks*TICK_DIV cycles.
- Cancel:
  - cancel[i] clears busy[i] at the next edge and suppresses done[i], even on the final tick.
  - cancel blocks a grant to channel i in the same cycle.
  - cancel on an IDLE channel is a no-op.
- Simultaneous events: cancel > completion > grant for the same channel. Other channels are independent; several channels may pulse done in the same cycle.
- Arithmetic: counters are unsigned CNT_W bits and never decrement below 0. The prescaler width is clog2(TICK_DIV), minimum 1.
- All outputs are registered.

Decomposition:
- Package tick_sched_pkg: default NCH, CNT_W, TICK_DIV constants; channel state enum {CH_IDLE, CH_RUN}; clog2 function.
- One natural sub-module, rr_arbiter: NCH-wide request vector in, one-hot grant and valid out, internal rotating pointer advanced on grant; reset pointer 0.
- Prescaler and countdown bank stay in tick_scheduler.

Test Plan:
- TICK_DIV=4, en=1, ch0 req at cycle 0 with ticks=3 -> ack0 and busy0 rise at cycle 1; tick at cycles 3, 7, 11; done0 high at cycle 12; busy0 low at 12.
- All four req at cycle 0, ticks=1 each -> ack0..ack3 in cycles 1, 2, 3, 4 in order. ch0 re-requests after its done while ch2 is also requesting -> pointer order is respected (grant to ch2 before ch0 if the pointer is at 2).
- ch1 req with ticks=0 -> ack1 and done1 both high in cycle 1; busy1 never asserts.
- ch2 loaded with ticks=2, cancel2 pulsed in the cycle of its final tick -> busy2 falls the next cycle; done2 never asserts.
- ch0 loaded with ticks=5, en dropped for 20 cycles mid-count -> tick stays 0, counter0 frozen; after en returns, done0 follows the remaining ticks exactly.
- rst asserted while ch0 and ch3 are busy and tick is high -> all outputs 0 at once. After release, the first tick occurs at cycle TICK_DIV-1 and no stale done appears.

Source files
------------

// File: rtl/tick_scheduler_pkg.sv
// Shared constants, channel state encoding and elaboration-time helpers
// for the tick scheduler and its round-robin arbiter.
package tick_sched_pkg;

  localparam int DEF_NCH      = 4;
  localparam int DEF_CNT_W    = 8;
  localparam int DEF_TICK_DIV = 50_000_000;

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_RUN  = 1'b1
  } ch_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  // Counter/index width for 'count' states, never narrower than one bit.
  function automatic int width_of(input int count);
    return (clog2(count) < 1) ? 1 : clog2(count);
  endfunction

endpackage

// File: rtl/tick_scheduler_rr_arbiter.sv
// Round-robin arbiter: one grant per cycle, searching from a rotating
// pointer that moves just past the last granted requester.
module rr_arbiter import tick_sched_pkg::*; #(
  parameter int N = DEF_NCH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant,
  output logic         valid
);

  localparam int PW  = width_of(N);
  localparam int PW1 = PW + 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] sel;
  logic [PW:0]   idx;

  always_comb begin
    grant = '0;
    valid = 1'b0;
    sel   = ptr;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      idx = {1'b0, ptr} + PW1'(i);
      if (idx >= PW1'(N)) idx = idx - PW1'(N);
      if (!valid && req[idx[PW-1:0]]) begin
        valid               = 1'b1;
        grant[idx[PW-1:0]]  = 1'b1;
        sel                 = idx[PW-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (valid) begin
      if (int'(sel) == N - 1) ptr <= '0;
      else                    ptr <= sel + 1'b1;
    end
  end

endmodule

// File: rtl/tick_scheduler.sv
// Shared timebase: one prescaler produces a tick every TICK_DIV enabled
// cycles; NCH channels are loaded round-robin and count ticks down to done.
module tick_scheduler import tick_sched_pkg::*; #(
  parameter int TICK_DIV = DEF_TICK_DIV,
  parameter int NCH      = DEF_NCH,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [NCH-1:0]       req,
  input  logic [NCH*CNT_W-1:0] ticks,
  input  logic [NCH-1:0]       cancel,
  output logic [NCH-1:0]       ack,
  output logic [NCH-1:0]       busy,
  output logic [NCH-1:0]       done,
  output logic                 tick
);

  localparam int              PS_W    = width_of(TICK_DIV);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);

  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
    return (v == '0) ? '0 : v - 1'b1;
  endfunction

  logic [PS_W-1:0]  ps_cnt;
  logic [PS_W-1:0]  ps_next;
  ch_state_e        state      [NCH];
  ch_state_e        state_next [NCH];
  logic [CNT_W-1:0] cnt        [NCH];
  logic [CNT_W-1:0] cnt_next   [NCH];
  logic [CNT_W-1:0] load_val;
  logic [NCH-1:0]   ack_next;
  logic [NCH-1:0]   done_next;
  logic [NCH-1:0]   eligible;
  logic [NCH-1:0]   grant;
  logic             grant_vld;

  // Prescaler: tick is registered so it lands in the cycle holding TICK_DIV-1
  always_comb ps_next = (ps_cnt == PS_LAST) ? '0 : ps_cnt + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ps_cnt <= '0;
      tick   <= 1'b0;
    end else begin
      tick <= en && (ps_next == PS_LAST);
      if (en) ps_cnt <= ps_next;
    end
  end

  // Arbitration: a channel is only offered once it is idle and its ack has cleared
  assign eligible = req & ~busy & ~ack & ~cancel;

  rr_arbiter #(.N(NCH)) u_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (eligible),
    .grant (grant),
    .valid (grant_vld)
  );

  // Countdown bank: cancel beats completion beats load
  always_comb begin
    load_val  = '0;
    ack_next  = '0;
    done_next = '0;
    for (int i = 0; i < NCH; i++) begin
      state_next[i] = state[i];
      cnt_next[i]   = cnt[i];
      load_val      = ticks[i*CNT_W +: CNT_W];
      if (state[i] == CH_RUN) begin
        if (cancel[i]) begin
          state_next[i] = CH_IDLE;
          cnt_next[i]   = '0;
        end else if (tick) begin
          if (cnt[i] <= CNT_W'(1)) begin
            state_next[i] = CH_IDLE;
            cnt_next[i]   = '0;
            done_next[i]  = 1'b1;
          end else begin
            cnt_next[i] = sat_dec(cnt[i]);
          end
        end
      end else if (grant_vld && grant[i]) begin
        ack_next[i] = 1'b1;
        if (load_val == '0) begin
          done_next[i] = 1'b1;
        end else begin
          state_next[i] = CH_RUN;
          cnt_next[i]   = load_val;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack  <= '0;
      done <= '0;
      for (int i = 0; i < NCH; i++) begin
        state[i] <= CH_IDLE;
        cnt[i]   <= '0;
      end
    end else begin
      ack  <= ack_next;
      done <= done_next;
      for (int i = 0; i < NCH; i++) begin
        state[i] <= state_next[i];
        cnt[i]   <= cnt_next[i];
      end
    end
  end

  always_comb begin
    busy = '0;
    for (int i = 0; i < NCH; i++) busy[i] = (state[i] == CH_RUN);
  end

endmodule

// File: tb/tb_tick_scheduler.sv
// Bench for tick_scheduler (TICK_DIV=4, NCH=4, CNT_W=8): directed vector table,
// hand-written corner sequences and random traffic against a reference model.
module tb_tick_scheduler;

  localparam int DIV = 4;
  localparam int N   = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] ticks = '0;
  logic [3:0]  cancel = '0;
  logic [3:0]  ack, busy, done;
  logic        tick;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  tick_scheduler #(.TICK_DIV(DIV), .NCH(N), .CNT_W(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .req    (req),
    .ticks  (ticks),
    .cancel (cancel),
    .ack    (ack),
    .busy   (busy),
    .done   (done),
    .tick   (tick)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: enabled-cycle count, remaining ticks per channel, rr pointer
  logic [3:0] m_ack, m_busy, m_done;
  logic       m_tick;
  int         m_rem [N];
  int         m_ptr;
  int         m_en_cnt;

  task automatic model_reset();
    m_ack = '0; m_busy = '0; m_done = '0; m_tick = 1'b0;
    m_ptr = 0; m_en_cnt = 0;
    for (int i = 0; i < N; i++) m_rem[i] = 0;
  endtask

  task automatic model_step(input logic e, input logic [3:0] r, input logic [31:0] t,
                            input logic [3:0] c);
    logic [3:0] n_ack, n_done, n_busy;
    logic       n_tick;
    int         tv;
    n_ack = '0; n_done = '0; n_busy = m_busy;
    n_tick = e && (((m_en_cnt + 1) % DIV) == DIV - 1);
    if (e) m_en_cnt++;
    for (int i = 0; i < N; i++) begin
      if (m_busy[i]) begin
        if (c[i]) n_busy[i] = 1'b0;
        else if (m_tick) begin
          m_rem[i]--;
          if (m_rem[i] == 0) begin
            n_done[i] = 1'b1;
            n_busy[i] = 1'b0;
          end
        end
      end
    end
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (r[i] && !m_busy[i] && !m_ack[i] && !c[i]) begin
        tv = int'(t[i*8 +: 8]);
        n_ack[i] = 1'b1;
        if (tv == 0) n_done[i] = 1'b1;
        else begin
          n_busy[i] = 1'b1;
          m_rem[i]  = tv;
        end
        m_ptr = (i + 1) % N;
        break;
      end
    end
    m_ack = n_ack; m_done = n_done; m_busy = n_busy; m_tick = n_tick;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic step(input logic e, input logic [3:0] r, input logic [31:0] t,
                      input logic [3:0] c);
    en = e; req = r; ticks = t; cancel = c;
    @(posedge clk);
    model_step(e, r, t, c);
    #1;
    cyc++;
    chk("model_ack",  32'(ack),  32'(m_ack));
    chk("model_busy", 32'(busy), 32'(m_busy));
    chk("model_done", 32'(done), 32'(m_done));
    chk("model_tick", 32'(tick), 32'(m_tick));
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; req = '0; ticks = '0; cancel = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    cyc = 0;
    chk("rst_out", {28'b0, ack | busy | done, tick}, 32'h0);
  endtask

  task automatic wait_idle(input int max_cyc);
    int n;
    n = 0;
    while ((busy != 0 || ack != 0 || done != 0) && n < max_cyc) begin
      step(1'b1, 4'b0, 32'h0, 4'b0);
      n++;
    end
    chk("idle_timeout", 32'(busy), 32'h0);
  endtask

  typedef struct {
    logic        en;
    logic [3:0]  req;
    logic [31:0] ticks;
    logic [3:0]  cancel;
    logic [3:0]  ack, busy, done;
    logic        tick;
  } vec_t;

  vec_t tbl [15];

  initial begin
    logic [3:0] r;
    int         nt, nt2;
    logic       fired;
    bit         pend [N];
    logic [7:0] tk   [N];
    logic [31:0] tword;

    // inputs during cycle i, outputs expected in cycle i+1
    tbl[0]  = '{1'b1, 4'b0001, 32'h0909_0903, 4'b0, 4'b0001, 4'b0001, 4'b0000, 1'b0};
    tbl[1]  = '{1'b1, 4'b0000, 32'h0,         4'b0, 4'b0000, 4'b0001, 4'b0000, 1'b0};
    tbl[2]  = '{1'b1, 4'b0000, 32'h0,         4'b0, 4'b0000, 4'b0001, 4'b0000, 1'b1};
    tbl[3]  = '{1'b1, 4'b0000, 32'h0,         4'b0, 4'b0000, 4'b0001, 4'b0000, 1'b0};
    tbl[4]  = '{1'b1, 4'b0000, 32'h0,         4'b0, 4'b0000, 4'b0001, 4'b0000, 1'b0};
    tbl[5]  = '{1'b1, 4'b0000, 32'h0,         4'b0, 4'b0000, 4'b0001, 4'b0000, 1'b0};
    tbl[6]  = '{1'b1, 4'b0000, 32'h0,         4'b0, 4'b0000, 4'b0001, 4'b0000, 1'b1};
    tbl[7]  = '{1'b1, 4'b0000, 32'h0,         4'b0, 4'b0000, 4'b0001, 4'b0000, 1'b0};
    tbl[8]  = '{1'b1, 4'b0000, 32'h0,         4'b0, 4'b0000, 4'b0001, 4'b0000, 1'b0};
    tbl[9]  = '{1'b1, 4'b0000, 32'h0,         4'b0, 4'b0000, 4'b0001, 4'b0000, 1'b0};
    tbl[10] = '{1'b1, 4'b0000, 32'h0,         4'b0, 4'b0000, 4'b0001, 4'b0000, 1'b1};
    tbl[11] = '{1'b1, 4'b0000, 32'h0,         4'b0, 4'b0000, 4'b0000, 4'b0001, 1'b0};
    tbl[12] = '{1'b1, 4'b0010, 32'h0505_0005, 4'b0, 4'b0010, 4'b0000, 4'b0010, 1'b0};
    tbl[13] = '{1'b1, 4'b0000, 32'h0,         4'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    tbl[14] = '{1'b1, 4'b0000, 32'h0,         4'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1};

    do_reset();
    for (int i = 0; i < 15; i++) begin
      step(tbl[i].en, tbl[i].req, tbl[i].ticks, tbl[i].cancel);
      chk("tbl_ack",  32'(ack),  32'(tbl[i].ack));
      chk("tbl_busy", 32'(busy), 32'(tbl[i].busy));
      chk("tbl_done", 32'(done), 32'(tbl[i].done));
      chk("tbl_tick", 32'(tick), 32'(tbl[i].tick));
    end

    // All four request together: acks in index order, one per cycle
    do_reset();
    r = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      step(1'b1, r, 32'h0101_0101, 4'b0);
      chk("rr_order", 32'(ack), 32'(4'b0001 << k));
      r = r & ~ack;
    end
    wait_idle(40);
    // Pointer parked at 2: ch2 must win over ch0
    step(1'b1, 4'b0010, 32'h0000_0500, 4'b0);
    chk("rr_ch1", 32'(ack), 32'h2);
    step(1'b1, 4'b0101, 32'h0001_0001, 4'b0);
    chk("rr_ptr2", 32'(ack), 32'h4);
    step(1'b1, 4'b0001, 32'h0000_0001, 4'b0);
    chk("rr_ch0", 32'(ack), 32'h1);
    wait_idle(60);

    // Cancel on the final tick of a two-tick countdown
    step(1'b1, 4'b0100, 32'h0002_0000, 4'b0);
    nt = 0; fired = 1'b0;
    for (int k = 0; k < 20 && !fired; k++) begin
      if (busy[2] && tick) nt++;
      if (nt == 2) begin
        step(1'b1, 4'b0, 32'h0, 4'b0100);
        fired = 1'b1;
        chk("cancel_busy", 32'(busy[2]), 32'h0);
        chk("cancel_done", 32'(done[2]), 32'h0);
      end else begin
        step(1'b1, 4'b0, 32'h0, 4'b0);
      end
    end
    chk("cancel_fired", 32'(fired), 32'h1);
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 4'b0, 32'h0, 4'b0);
      chk("cancel_nodone", 32'(done[2]), 32'h0);
    end

    // Enable dropped for 20 cycles in the middle of a five-tick countdown
    wait_idle(20);
    step(1'b1, 4'b0001, 32'h0000_0005, 4'b0);
    nt = 0;
    for (int k = 0; k < 20 && nt < 2; k++) begin
      if (busy[0] && tick) nt++;
      if (nt < 2) step(1'b1, 4'b0, 32'h0, 4'b0);
    end
    chk("en_pre_ticks", 32'(nt), 32'd2);
    for (int k = 0; k < 20; k++) begin
      step(1'b0, 4'b0, 32'h0, 4'b0);
      chk("en_off_tick", 32'(tick), 32'h0);
      chk("en_off_busy", 32'(busy[0]), 32'h1);
    end
    nt2 = 0; fired = 1'b0;
    for (int k = 0; k < 40 && !fired; k++) begin
      if (busy[0] && tick) nt2++;
      step(1'b1, 4'b0, 32'h0, 4'b0);
      if (done[0]) fired = 1'b1;
    end
    chk("en_done_seen", 32'(fired), 32'h1);
    chk("en_post_ticks", 32'(nt2), 32'd3);

    // Reset while ch0 and ch3 are counting and tick is high
    wait_idle(20);
    r = 4'b1001;
    for (int k = 0; k < 6 && r != 0; k++) begin
      step(1'b1, r, 32'h3200_0032, 4'b0);
      r = r & ~ack;
    end
    for (int k = 0; k < 10 && !(tick && busy == 4'b1001); k++) step(1'b1, 4'b0, 32'h0, 4'b0);
    chk("pre_rst_state", {27'b0, busy, tick}, {27'b0, 4'b1001, 1'b1});
    rst = 1'b1;
    #1;
    chk("rst_async", {28'b0, ack | busy | done, tick}, 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    chk("rst_cycle0", {28'b0, ack | busy | done, tick}, 32'h0);
    for (int k = 0; k < 12; k++) begin
      step(1'b1, 4'b0, 32'h0, 4'b0);
      chk("rst_tick_phase", 32'(tick), 32'((cyc % DIV) == DIV - 1));
      chk("rst_no_done", 32'(done), 32'h0);
    end

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < N; i++) begin pend[i] = 1'b0; tk[i] = '0; end
    for (int k = 0; k < 500; k++) begin
      r = '0; tword = '0;
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 3) == 0) begin
          pend[i] = 1'b1;
          tk[i]   = 8'($urandom_range(0, 3));
        end
        r[i] = pend[i];
        tword[i*8 +: 8] = tk[i];
      end
      step($urandom_range(0, 9) != 0, r, tword,
           {$urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0,
            $urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0});
      for (int i = 0; i < N; i++) if (ack[i]) pend[i] = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
